// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-access (load/store) stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_WB
  } state_t;

  // Wide enough for any response timeout from 1 to 255 cycles.
  localparam int CNT_W = 8;

  localparam int EXC_OVF  = 0;
  localparam int EXC_ADDR = 1;
  localparam int EXC_BUS  = 2;
  localparam int EXC_W    = 3;

endpackage

// File: rtl/lsu_stage.sv
// Memory-access stage: runs a valid/ready data-memory transaction for lw/sw,
// passes other ALU results through, and emits one registered writeback record.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_rsp_valid,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        exc_ovf,
  output logic        exc_addr,
  output logic        exc_bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [EXC_W-1:0] BUS_EXC = EXC_W'(1) << EXC_BUS;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               load_q;
  logic               rw_q;
  logic [EXC_W-1:0]   exc;

  logic               is_mem;
  logic               misaligned;
  logic               early_wb;
  logic [EXC_W-1:0]   early_exc;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    is_mem     = mem_read || mem_write;
    misaligned = is_mem && (alu_out[1:0] != 2'b00);
    early_wb   = alu_overflow || !is_mem || misaligned;
    early_exc  = '0;
    // Overflow outranks misalignment; only one flag per record.
    early_exc[EXC_OVF]  = alu_overflow;
    early_exc[EXC_ADDR] = !alu_overflow && misaligned;
  end

  assign exc_ovf  = exc[EXC_OVF];
  assign exc_addr = exc[EXC_ADDR];
  assign exc_bus  = exc[EXC_BUS];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      load_q       <= 1'b0;
      rw_q         <= 1'b0;
      ex_ready     <= 1'b1;
      dm_req_valid <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      exc          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            ex_ready <= 1'b0;
            wb_rd    <= rd_in;
            load_q   <= mem_read;
            rw_q     <= reg_write_in;
            if (early_wb) begin
              // Exceptions and non-memory ops skip the bus entirely.
              state        <= S_WB;
              wb_valid     <= 1'b1;
              wb_data      <= is_mem ? 32'h0 : alu_out;
              wb_reg_write <= reg_write_in && !alu_overflow && !misaligned && !mem_write;
              exc          <= early_exc;
            end else begin
              state        <= S_REQ;
              dm_req_valid <= 1'b1;
              dm_we        <= mem_write;
              dm_addr      <= alu_out;
              dm_wdata     <= store_data;
            end
          end
        end

        S_REQ: begin
          if (dm_req_ready) begin
            dm_req_valid <= 1'b0;
            if (load_q) begin
              state <= S_RSP;
              cnt   <= '0;
            end else begin
              state        <= S_WB;
              wb_valid     <= 1'b1;
              wb_data      <= '0;
              wb_reg_write <= 1'b0;
              exc          <= '0;
            end
          end
        end

        S_RSP: begin
          cnt <= cnt + 1'b1;
          // A response arriving in the final waiting cycle beats the timeout.
          if (dm_rsp_valid) begin
            state        <= S_WB;
            wb_valid     <= 1'b1;
            wb_data      <= dm_rdata;
            wb_reg_write <= rw_q;
            exc          <= '0;
          end else if (cnt == TO_LAST) begin
            state        <= S_WB;
            wb_valid     <= 1'b1;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            exc          <= BUS_EXC;
          end
        end

        S_WB: begin
          state    <= S_IDLE;
          wb_valid <= 1'b0;
          ex_ready <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage, built with a 4-cycle response timeout.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, mem_read, mem_write, alu_overflow, reg_write_in;
  logic [31:0] alu_out, store_data;
  logic [4:0]  rd_in;
  logic        dm_req_valid, dm_req_ready, dm_we, dm_rsp_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_reg_write, exc_ovf, exc_addr, exc_bus;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_errors = 0;

  lsu_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .exc_ovf(exc_ovf), .exc_addr(exc_addr), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are read 1 ns after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [31:0] a,
                       input logic ovf, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw);
    ex_valid = 1'b1; mem_read = rd_op; mem_write = wr_op; alu_out = a;
    alu_overflow = ovf; store_data = sd; rd_in = rd; reg_write_in = rw;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_overflow = 1'b0;
    reg_write_in = 1'b0;
  endtask

  initial begin
    int waited;
    int stray_wb;
    rst_n = 1'b0;
    idle_inputs();
    alu_out = '0; store_data = '0; rd_in = '0;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rdata = '0;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_req_valid", 32'(dm_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_exc", {29'd0, exc_ovf, exc_addr, exc_bus}, 32'd0);
    step();

    // addu: writeback the cycle after accept, no memory request
    issue(1'b0, 1'b0, 32'h0000_1234, 1'b0, 32'h0, 5'd5, 1'b1);
    step();
    idle_inputs();
    check("addu_wb_valid", 32'(wb_valid), 32'd1);
    check("addu_wb_data", wb_data, 32'h0000_1234);
    check("addu_wb_rd", 32'(wb_rd), 32'd5);
    check("addu_reg_write", 32'(wb_reg_write), 32'd1);
    check("addu_no_req", 32'(dm_req_valid), 32'd0);
    check("addu_ex_ready", 32'(ex_ready), 32'd0);
    step();
    check("addu_wb_done", 32'(wb_valid), 32'd0);
    check("addu_ready_back", 32'(ex_ready), 32'd1);

    // lw 0x100 with dm_req_ready low for 3 cycles, response 2 cycles after handshake
    issue(1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0, 5'd7, 1'b1);
    step();
    idle_inputs();
    alu_out = 32'hFFFF_FFF0;
    for (int i = 0; i < 3; i++) begin
      check("lw_req_valid_hold", 32'(dm_req_valid), 32'd1);
      check("lw_addr_hold", dm_addr, 32'h0000_0100);
      check("lw_we", 32'(dm_we), 32'd0);
      if (i < 2) step();
    end
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    check("lw_req_dropped", 32'(dm_req_valid), 32'd0);
    step();
    dm_rsp_valid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    check("lw_no_early_wb", 32'(wb_valid), 32'd0);
    step();
    dm_rsp_valid = 1'b0; dm_rdata = 32'h0;
    check("lw_wb_valid", 32'(wb_valid), 32'd1);
    check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    check("lw_reg_write", 32'(wb_reg_write), 32'd1);
    check("lw_wb_rd", 32'(wb_rd), 32'd7);
    check("lw_exc", {29'd0, exc_ovf, exc_addr, exc_bus}, 32'd0);
    step();

    // sw 0x104, memory ready immediately
    dm_req_ready = 1'b1;
    issue(1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'hCAFE_0001, 5'd0, 1'b0);
    step();
    idle_inputs();
    check("sw_req_valid", 32'(dm_req_valid), 32'd1);
    check("sw_we", 32'(dm_we), 32'd1);
    check("sw_addr", dm_addr, 32'h0000_0104);
    check("sw_wdata", dm_wdata, 32'hCAFE_0001);
    step();
    dm_req_ready = 1'b0;
    check("sw_wb_valid", 32'(wb_valid), 32'd1);
    check("sw_reg_write", 32'(wb_reg_write), 32'd0);
    check("sw_req_dropped", 32'(dm_req_valid), 32'd0);
    step();

    // Misaligned lw 0x102: no request, address exception
    issue(1'b1, 1'b0, 32'h0000_0102, 1'b0, 32'h0, 5'd9, 1'b1);
    step();
    idle_inputs();
    check("mis_wb_valid", 32'(wb_valid), 32'd1);
    check("mis_no_req", 32'(dm_req_valid), 32'd0);
    check("mis_exc", {29'd0, exc_ovf, exc_addr, exc_bus}, 32'b010);
    check("mis_reg_write", 32'(wb_reg_write), 32'd0);
    check("mis_wb_data", wb_data, 32'h0);
    step();

    // Overflowing op with mem_write and an unaligned address: overflow alone is reported
    issue(1'b0, 1'b1, 32'h0000_0207, 1'b1, 32'h1111_2222, 5'd3, 1'b1);
    step();
    idle_inputs();
    check("ovf_wb_valid", 32'(wb_valid), 32'd1);
    check("ovf_no_req", 32'(dm_req_valid), 32'd0);
    check("ovf_exc", {29'd0, exc_ovf, exc_addr, exc_bus}, 32'b100);
    check("ovf_reg_write", 32'(wb_reg_write), 32'd0);
    step();

    // Timeout: lw with no response; 4 waiting cycles after the handshake edge, then WB
    dm_req_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0300, 1'b0, 32'h0, 5'd4, 1'b1);
    step();
    idle_inputs();
    step();
    dm_req_ready = 1'b0;
    waited = 0;
    while (!wb_valid && waited < 20) begin
      step();
      waited++;
    end
    check("to_wait_cycles", 32'(waited), 32'd4);
    check("to_exc", {29'd0, exc_ovf, exc_addr, exc_bus}, 32'b001);
    check("to_reg_write", 32'(wb_reg_write), 32'd0);
    check("to_wb_data", wb_data, 32'h0);
    step();

    // Response on the 4th waiting cycle beats the timeout
    dm_req_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0400, 1'b0, 32'h0, 5'd6, 1'b1);
    step();
    idle_inputs();
    step();
    dm_req_ready = 1'b0;
    step(); step(); step();
    check("late_no_early_wb", 32'(wb_valid), 32'd0);
    dm_rsp_valid = 1'b1; dm_rdata = 32'h55AA_33CC;
    step();
    dm_rsp_valid = 1'b0;
    check("late_wb_valid", 32'(wb_valid), 32'd1);
    check("late_wb_data", wb_data, 32'h55AA_33CC);
    check("late_exc", {29'd0, exc_ovf, exc_addr, exc_bus}, 32'd0);
    check("late_reg_write", 32'(wb_reg_write), 32'd1);
    step();

    // Reset while waiting in RSP: immediate idle, no writeback, stray responses ignored
    dm_req_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0500, 1'b0, 32'h0, 5'd8, 1'b1);
    step();
    idle_inputs();
    step();
    dm_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rstmid_ex_ready", 32'(ex_ready), 32'd1);
    check("rstmid_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_wb = 0;
    dm_rsp_valid = 1'b1; dm_rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_valid) stray_wb++;
    end
    dm_rsp_valid = 1'b0;
    check("rstmid_stray_wb", 32'(stray_wb), 32'd0);
    check("rstmid_ready_after", 32'(ex_ready), 32'd1);
    check("rstmid_wb_data", wb_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Memory-access stage directly downstream of the execute-stage ALU in the MIPS datapath. It consumes the ALU result as an effective address (lw/sw) or a pass-through value (all other ops), runs a valid/ready transaction against the data memory, and delivers one registered writeback record per accepted instruction. It stalls the execute stage while a memory access is outstanding. It also converts ALU overflow and misalignment into exceptions that suppress the access.

## Interface
- TIMEOUT, 255: max cycles waiting for `dm_rsp_valid` before bus error; 1..255.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready.
- mem_read  in  1  lw.
- mem_write  in  1  sw; mem_read && mem_write never both 1.
- alu_out  in  32  ALU result / effective address.
- alu_overflow  in  1  ALU overflow flag (addi only).
- store_data  in  32  busB value for sw.
- rd_in  in  5  destination register.
- reg_write_in  in  1  instruction writes rd.
- dm_req_valid  out  1  memory request.
- dm_req_ready  in  1  memory accepts request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word-aligned address.
- dm_wdata  out  32  write data.
- dm_rsp_valid  in  1  read data returned.
- dm_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse, writeback record valid.
- wb_data  out  32  load data or ALU result.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register file write enable.
- exc_ovf  out  1  overflow exception, valid with wb_valid.
- exc_addr  out  1  misaligned address, valid with wb_valid.
- exc_bus  out  1  response timeout, valid with wb_valid.

## Operation
- FSM states: IDLE, REQ, RSP, WB.
- IDLE: ex_ready=1. On accept, latch all inputs.
  - Non-memory op, overflow, or misaligned memory op (alu_out[1:0]!=0) -> WB.
  - Otherwise -> REQ.
- REQ: dm_req_valid=1. dm_addr, dm_we and dm_wdata stay stable until dm_req_ready.
  - On handshake: load -> RSP with counter cleared; store -> WB.
- RSP: counter increments each cycle.
  - dm_rsp_valid -> capture dm_rdata, go to WB.
  - Counter reaching TIMEOUT without a response -> exc_bus, go to WB.
  - dm_rsp_valid in the same cycle as the timeout: the response wins.
- WB: wb_valid=1 for exactly one cycle, then IDLE. ex_ready=0 in REQ/RSP/WB.
- wb_data rules:
  - Non-memory op: latched alu_out.
  - Successful load: captured dm_rdata.
  - Otherwise: 0.
- wb_reg_write = latched reg_write_in && no exception. A store, or any exception, gives 0.
- Exception priority: exc_ovf > exc_addr > exc_bus. Only one exception flag is set per record.
- An overflowing or misaligned op never raises dm_req_valid.
- dm_rsp_valid outside RSP is ignored.

## Timing
- Reset (async assert, sync deassert handled externally): state IDLE, counter 0. All outputs 0 except ex_ready=1.
- Reset mid-transaction abandons the request; no wb_valid is produced.
- Non-memory op accepted in cycle N: wb_valid in N+1.
- Load: dm_req_valid from N+1. Handshake in cycle H, response in cycle R>H, wb_valid in R+1.
  - Best case: N+1 handshake, N+2 response, N+3 wb_valid.
- Store: handshake in H, wb_valid in H+1.
- Throughput: one instruction per 2 cycles minimum (accept, WB).

## Structure
- Package `lsu_pkg`: state enum, TIMEOUT width constant, exception bit positions.
- Single module, no sub-module. The timeout counter stays inline with the FSM.

## Test plan
- addu result 0x0000_1234, rd=5, reg_write=1 -> wb_valid next cycle, wb_data=0x1234, wb_rd=5, no dm_req_valid.
- lw addr 0x100, dm_req_ready held low 3 cycles, rsp 2 cycles later with 0xDEADBEEF -> address held stable; wb_data=0xDEADBEEF, wb_reg_write=1, one cycle after rsp.
- sw addr 0x104, data 0xCAFE0001, ready immediately -> dm_we=1 with that address/data, wb_valid next cycle, wb_reg_write=0.
- lw addr 0x102 -> no request, exc_addr=1, wb_reg_write=0. addi with alu_overflow=1 and mem_write=1 -> exc_ovf=1 only, no request.
- TIMEOUT=4, lw with no response -> exc_bus=1, wb_valid exactly 4 cycles after handshake. Response on the 4th cycle -> data returned, exc_bus=0.
- rst_n low while in RSP -> immediate IDLE, ex_ready=1, no wb_valid, later stray dm_rsp_valid ignored.
